// File: rtl/spike_tally.sv
// spike_tally: per-neuron spike counters plus a sequential winner scan.
// Spike events are counted only while idle. An i_eval pulse then scans
// the counters one per cycle, lowest index first; on a tie the lower
// index wins. The result is presented with a one-cycle o_done pulse.
// Optional build macro: SPIKE_TALLY_SAT_EN makes the counters saturate
// at their maximum value. When it is undefined, the counters wrap to 0.
module spike_tally #(
  parameter int NUM_NEURON = 18,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_spike,
  input  logic [4:0]       i_neuron_idx,
  input  logic             i_clear,
  input  logic             i_eval,
  input  logic [4:0]       i_rd_idx,
  output logic [CNT_W-1:0] o_rd_count,
  output logic             o_busy,
  output logic             o_done,
  output logic [4:0]       o_winner,
  output logic [CNT_W-1:0] o_win_count
);

  localparam logic [5:0]       NUM_L    = 6'(NUM_NEURON);
  localparam logic [4:0]       LAST_IDX = 5'(NUM_NEURON - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r [NUM_NEURON];
  logic [4:0]       scan_idx_r;
  logic [4:0]       best_idx_r;
  logic [CNT_W-1:0] best_cnt_r;

  logic             spike_hit_s;
  logic [CNT_W-1:0] scan_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic [4:0]       nxt_best_idx_s;
  logic [CNT_W-1:0] nxt_best_cnt_s;

  // A neuron index is usable only when it addresses an existing counter.
  function automatic logic idx_in_range(input logic [4:0] idx);
    return ({1'b0, idx} < NUM_L);
  endfunction

  // This is the counter value after one more spike. It either saturates
  // or wraps, depending on the build.
  function automatic logic [CNT_W-1:0] bump_count(input logic [CNT_W-1:0] cnt);
`ifdef SPIKE_TALLY_SAT_EN
    return (cnt == CNT_MAX) ? CNT_MAX : (cnt + CNT_ONE);
`else
    return cnt + CNT_ONE;
`endif
  endfunction

  // A spike counts only while idle, for a valid index, and when no clear is pending.
  always_comb begin
    spike_hit_s = i_valid && i_spike && (state_r == S_IDLE) &&
                  idx_in_range(i_neuron_idx) && !i_clear;
  end

  // Select the counter at the current scan position.
  always_comb begin
    scan_cnt_s = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      scan_cnt_s = (scan_idx_r == 5'(i)) ? cnt_r[i] : scan_cnt_s;
    end
  end

  // Readout mux. An out-of-range address matches no counter and so yields zero.
  always_comb begin
    rd_cnt_s = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      rd_cnt_s = (i_rd_idx == 5'(i)) ? cnt_r[i] : rd_cnt_s;
    end
  end

  // Running maximum. Index 0 seeds the scan, and a later index replaces
  // the current best only when its count is strictly greater.
  always_comb begin
    if (scan_idx_r == 5'd0) begin
      nxt_best_idx_s = 5'd0;
      nxt_best_cnt_s = scan_cnt_s;
    end else if (scan_cnt_s > best_cnt_r) begin
      nxt_best_idx_s = scan_idx_r;
      nxt_best_cnt_s = scan_cnt_s;
    end else begin
      nxt_best_idx_s = best_idx_r;
      nxt_best_cnt_s = best_cnt_r;
    end
  end

  // Counter bank: reset and clear take priority over a spike increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (i_clear) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (spike_hit_s) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        if (i_neuron_idx == 5'(i)) begin
          cnt_r[i] <= bump_count(cnt_r[i]);
        end
      end
    end
  end

  // Registered readout port.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rd_count <= '0;
    end else begin
      o_rd_count <= rd_cnt_s;
    end
  end

  // Scan FSM. It drives the registered busy, done and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      scan_idx_r  <= 5'd0;
      best_idx_r  <= 5'd0;
      best_cnt_r  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_winner    <= 5'd0;
      o_win_count <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_eval) begin
            state_r    <= S_SCAN;
            scan_idx_r <= 5'd0;
            o_busy     <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_SCAN: begin
          best_idx_r <= nxt_best_idx_s;
          best_cnt_r <= nxt_best_cnt_s;
          if (scan_idx_r == LAST_IDX) begin
            state_r     <= S_DONE;
            o_done      <= 1'b1;
            o_winner    <= nxt_best_idx_s;
            o_win_count <= nxt_best_cnt_s;
          end else begin
            scan_idx_r <= scan_idx_r + 5'd1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_tally.sv
// Directed self-checking bench for spike_tally. It uses default parameters.
// The expected saturation result follows the SPIKE_TALLY_SAT_EN build macro.
module tb_spike_tally;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_spike = 1'b0;
  logic [4:0] i_neuron_idx = 5'd0;
  logic       i_clear = 1'b0;
  logic       i_eval = 1'b0;
  logic [4:0] i_rd_idx = 5'd0;
  logic [7:0] o_rd_count;
  logic       o_busy;
  logic       o_done;
  logic [4:0] o_winner;
  logic [7:0] o_win_count;

  int total = 0;
  int bad   = 0;

  spike_tally dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_spike     (i_spike),
    .i_neuron_idx(i_neuron_idx),
    .i_clear     (i_clear),
    .i_eval      (i_eval),
    .i_rd_idx    (i_rd_idx),
    .o_rd_count  (o_rd_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_winner    (o_winner),
    .o_win_count (o_win_count)
  );

  always #5 clk = ~clk;

  // Advance one clock, then settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic spike(input logic [4:0] idx, input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1; i_spike = 1'b1; i_neuron_idx = idx;
      tick();
    end
    i_valid = 1'b0; i_spike = 1'b0;
  endtask

  task automatic clear_all();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input int exp);
    i_rd_idx = idx;
    tick();
    check(tag, int'(o_rd_count), exp);
  endtask

  // Pulse i_eval, then wait (bounded) for o_done. The returned latency
  // counts cycles from the i_eval cycle.
  task automatic run_eval(output int lat);
    i_eval = 1'b1;
    tick();
    i_eval = 1'b0;
    lat = 1;
    while (!o_done && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    int win;
    int wcnt;

    // Reset state.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_done", int'(o_done), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_winner", int'(o_winner), 0);
    check("rst_wcnt", int'(o_win_count), 0);
    check("rst_rd", int'(o_rd_count), 0);

    // Count and winner.
    clear_all();
    spike(5'd5, 3);
    spike(5'd12, 7);
    rd("cnt5", 5'd5, 3);
    rd("cnt12", 5'd12, 7);
    rd("cnt0", 5'd0, 0);
    rd("rd_oob", 5'd25, 0);
    run_eval(lat);
    check("lat", lat, 19);
    check("win_idx", int'(o_winner), 12);
    check("win_cnt", int'(o_win_count), 7);
    check("busy_done", int'(o_busy), 1);
    tick();
    check("done_pulse", int'(o_done), 0);
    check("busy_after", int'(o_busy), 0);
    check("win_hold", int'(o_winner), 12);

    // Tie between two neurons, plus a non-spiking valid event.
    clear_all();
    spike(5'd3, 4);
    spike(5'd9, 4);
    i_valid = 1'b1; i_spike = 1'b0; i_neuron_idx = 5'd7;
    tick();
    i_valid = 1'b0;
    rd("nospike7", 5'd7, 0);
    run_eval(lat);
    check("tie_lat", lat, 19);
    check("tie_idx", int'(o_winner), 3);
    check("tie_cnt", int'(o_win_count), 4);

    // All counters zero.
    clear_all();
    run_eval(lat);
    check("zero_idx", int'(o_winner), 0);
    check("zero_cnt", int'(o_win_count), 0);

    // Collisions: a clear wins over a spike, and an out-of-range index is ignored.
    clear_all();
    spike(5'd1, 2);
    i_clear = 1'b1; i_valid = 1'b1; i_spike = 1'b1; i_neuron_idx = 5'd2;
    tick();
    i_clear = 1'b0; i_valid = 1'b0; i_spike = 1'b0;
    rd("clr_win2", 5'd2, 0);
    rd("clr_win1", 5'd1, 0);
    spike(5'd1, 2);
    spike(5'd20, 1);
    for (int k = 0; k < 18; k++) begin
      rd("oob_keep", 5'(k), (k == 1) ? 2 : 0);
    end

    // Busy: a spike and a second i_eval during the scan are both dropped.
    clear_all();
    spike(5'd6, 2);
    i_eval = 1'b1;
    tick();
    i_eval = 1'b0;
    tick(); tick(); tick();
    check("busy_scan", int'(o_busy), 1);
    i_valid = 1'b1; i_spike = 1'b1; i_neuron_idx = 5'd1; i_eval = 1'b1;
    tick();
    i_valid = 1'b0; i_spike = 1'b0; i_eval = 1'b0;
    dones = 0; win = -1; wcnt = -1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (o_done) begin
        dones++;
        win = int'(o_winner);
        wcnt = int'(o_win_count);
      end
    end
    check("one_done", dones, 1);
    check("busy_win", win, 6);
    check("busy_wcnt", wcnt, 2);
    rd("busy_drop1", 5'd1, 0);

    // A clear during the scan zeroes the counters that are not yet scanned.
    clear_all();
    spike(5'd4, 3);
    spike(5'd15, 5);
    i_eval = 1'b1;
    tick();
    i_eval = 1'b0;
    tick(); tick();
    clear_all();
    lat = 0;
    while (!o_done && lat < 40) begin
      tick();
      lat++;
    end
    check("midclr_done", int'(o_done), 1);
    check("midclr_idx", int'(o_winner), 0);
    check("midclr_cnt", int'(o_win_count), 0);
    tick();

    // Counter overflow: 300 spikes on one neuron.
    clear_all();
    spike(5'd0, 300);
`ifdef SPIKE_TALLY_SAT_EN
    rd("sat0", 5'd0, 255);
`else
    rd("wrap0", 5'd0, 44);
`endif

    // Reset in the middle of a scan.
    clear_all();
    spike(5'd8, 3);
    i_eval = 1'b1;
    tick();
    i_eval = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("pre_rst_busy", int'(o_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_done), 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_done) dones++;
    end
    check("midrst_nodone", dones, 0);
    rd("midrst_cnt8", 5'd8, 0);
    rd("midrst_cnt0", 5'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_tally.md
SPIKE_TALLY -- requirements
Module: spike_tally

Interface
REQ-001 The block SHALL have parameter NUM_NEURON, default 18, number of neurons per sample (valid indices 0..NUM_NEURON-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of each per-neuron spike counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous reset, active-high.
REQ-006 Port i_valid, input, 1: one neuron update finished this cycle; driven by the neuron-update stage's o_valid.
REQ-007 Port i_spike, input, 1: the updated neuron fired; sampled only when i_valid=1.
REQ-008 Port i_neuron_idx, input, 5: index of the updated neuron; sampled only when i_valid=1.
REQ-009 Port i_clear, input, 1: single-cycle pulse that zeroes all counters at the start of a new sample.
REQ-010 Port i_eval, input, 1: single-cycle pulse that starts the winner scan.
REQ-011 Port i_rd_idx, input, 5: readout address for o_rd_count.
REQ-012 Port o_rd_count, output, CNT_W: registered count of neuron i_rd_idx.
REQ-013 Port o_busy, output, 1: high while the winner scan is in progress.
REQ-014 Port o_done, output, 1: one-cycle pulse when o_winner and o_win_count are valid.
REQ-015 Port o_winner, output, 5: index of the neuron with the highest count.
REQ-016 Port o_win_count, output, CNT_W: count of the winning neuron.

Function
REQ-017 The block SHALL hold NUM_NEURON registered counters of CNT_W bits each.
REQ-018 In S_IDLE, when i_valid=1, i_spike=1 and i_neuron_idx<NUM_NEURON, counter[i_neuron_idx] SHALL increment on that clock edge, so the new value is visible one cycle later.
REQ-019 An event with i_neuron_idx>=NUM_NEURON SHALL be ignored.
REQ-020 An event with i_valid=1 and i_spike=0 SHALL leave all counters unchanged.
REQ-021 i_clear SHALL zero all counters on the next edge, in any state.
REQ-022 If i_clear and a spike event occur in the same cycle, the clear SHALL win and the spike SHALL be dropped.
REQ-023 The FSM states SHALL be S_IDLE, S_SCAN and S_DONE.
REQ-024 FSM transitions SHALL be:
- S_IDLE -> S_SCAN on i_eval=1;
- S_SCAN -> S_DONE after examining index NUM_NEURON-1;
- S_DONE -> S_IDLE unconditionally.
REQ-025 S_SCAN SHALL examine one counter per cycle, indices 0 to NUM_NEURON-1 in order, so S_SCAN lasts NUM_NEURON cycles.
REQ-026 The running maximum SHALL update only when a counter is strictly greater than the current maximum, so a tie goes to the lowest index.
REQ-027 The scan SHALL start with best index 0 and best count equal to counter[0].
REQ-028 o_done SHALL be high exactly during S_DONE; from i_eval to o_done the latency is NUM_NEURON+1 cycles (19 at the default).
REQ-029 o_winner and o_win_count SHALL hold their values until the next scan completes or reset.
REQ-030 o_busy SHALL be high in S_SCAN and S_DONE.
REQ-031 Spike events arriving while o_busy=1 SHALL be dropped, so the scan sees a frozen snapshot.
REQ-032 i_eval while o_busy=1 SHALL be ignored.
REQ-033 i_clear during S_SCAN SHALL zero the counters and the scan SHALL continue over the zeroed values.
REQ-034 o_rd_count SHALL equal counter[i_rd_idx] one cycle after i_rd_idx is applied, and SHALL be 0 when i_rd_idx>=NUM_NEURON.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL:
- set all counters to 0 and the FSM to S_IDLE;
- drive o_done=0, o_busy=0, o_winner=0, o_win_count=0 and o_rd_count=0.
REQ-036 Reset asserted mid-scan SHALL abort the scan and produce no o_done pulse.

Configuration
REQ-037 With SPIKE_TALLY_SAT_EN defined, a counter at 2^CNT_W-1 SHALL hold that value on further spikes (saturate).
REQ-038 Without SPIKE_TALLY_SAT_EN, a counter at 2^CNT_W-1 SHALL wrap to 0 on the next spike.

Verification
REQ-039 Count and winner: 3 spikes on idx 5 and 7 spikes on idx 12, then i_eval -> o_done exactly 19 cycles later with o_winner=12 and o_win_count=7.
REQ-040 Tie: 4 spikes each on idx 3 and 9 -> o_winner=3, o_win_count=4; with all counts zero -> o_winner=0, o_win_count=0.
REQ-041 Saturation: 300 spikes on idx 0 -> o_rd_count(0)=255 with SPIKE_TALLY_SAT_EN, and 44 without it.
REQ-042 Collisions: i_clear in the same cycle as a spike on idx 2 -> counter[2]=0; a spike on idx 20 -> all counters unchanged.
REQ-043 Busy behaviour: a spike on idx 1 during S_SCAN is not counted; a second i_eval during the scan produces only one o_done.
REQ-044 Reset mid-scan at scan cycle 10 -> no o_done, o_busy=0 the next cycle, and all counts read 0.
